// File: rtl/grf_wb_pkg.sv
// grf_wb_pkg: shared widths and the queue entry layout for the GRF write-back queue.
//   ADDR_W     - register address width
//   DATA_W     - data and pc width
//   wb_entry_t - one pending register write {addr, data, pc}
package grf_wb_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] pc;
    } wb_entry_t;

endpackage

// File: rtl/grf_wb_match.sv
// grf_wb_match: finds the youngest occupied entry whose address equals look_addr.
//   valid     - per-slot occupancy
//   addr/data - per-slot stored address and data
//   tail      - next write slot; the youngest entry sits at tail-1
//   look_addr - register being looked up ($0 never hits)
//   hit       - some occupied slot matches
//   look_data - data of the youngest match, 0 when there is no hit
module grf_wb_match #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic [DEPTH-1:0]             valid,
    input  logic [DEPTH-1:0][ADDR_W-1:0] addr,
    input  logic [DEPTH-1:0][DATA_W-1:0] data,
    input  logic [$clog2(DEPTH)-1:0]     tail,
    input  logic [ADDR_W-1:0]            look_addr,
    output logic                         hit,
    output logic [DATA_W-1:0]            look_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    // Walk from oldest (age DEPTH) to youngest (age 1) so the youngest match is written last.
    // Age DEPTH truncates to offset 0, i.e. the slot at tail itself.
    always_comb begin
        hit       = 1'b0;
        look_data = '0;
        idx       = '0;
        for (int i = DEPTH; i >= 1; i--) begin
            idx = tail - PTR_W'(i);
            if (valid[idx] && addr[idx] == look_addr && look_addr != '0) begin
                hit       = 1'b1;
                look_data = data[idx];
            end
        end
    end

endmodule

// File: rtl/grf_wb_queue.sv
// grf_wb_queue: in-order write-back queue feeding the GRF write port with forwarding lookups.
//   clk, reset_n             - clock, asynchronous active-low reset
//   in_valid/in_ready        - request handshake; in_addr/in_data/in_pc carry the write
//   drain_en                 - allows the head entry to commit this cycle
//   wr_en/wr_addr/wr_data/wr_pc - GRF write port (head entry, zeros while empty)
//   lookN_addr/hit/data      - youngest pending value for a register, two ports
//   count/empty/full         - occupancy
module grf_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = grf_wb_pkg::ADDR_W,
    parameter int DATA_W = grf_wb_pkg::DATA_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_addr,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [DATA_W-1:0]          in_pc,
    input  logic                       drain_en,
    output logic                       wr_en,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [DATA_W-1:0]          wr_data,
    output logic [DATA_W-1:0]          wr_pc,
    input  logic [ADDR_W-1:0]          look1_addr,
    output logic                       look1_hit,
    output logic [DATA_W-1:0]          look1_data,
    input  logic [ADDR_W-1:0]          look2_addr,
    output logic                       look2_hit,
    output logic [DATA_W-1:0]          look2_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    import grf_wb_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t                    mem [DEPTH];
    logic [DEPTH-1:0]             vld;
    logic [PTR_W-1:0]             head;
    logic [PTR_W-1:0]             tail;
    logic [CNT_W-1:0]             cnt;
    logic                         push;
    logic                         pop;
    logic [DEPTH-1:0][ADDR_W-1:0] m_addr;
    logic [DEPTH-1:0][DATA_W-1:0] m_data;

    assign count = cnt;
    assign empty = cnt == '0;
    assign full  = cnt == CNT_W'(DEPTH);
    assign wr_en = drain_en & ~empty;
    assign pop   = wr_en;
    // A pop frees a slot in the same edge, so a full queue still accepts when draining.
    assign in_ready = reset_n & (~full | pop);
    // $0 writes complete the handshake but are never stored.
    assign push = in_valid & in_ready & (in_addr != '0);

    assign wr_addr = empty ? '0 : mem[head].addr;
    assign wr_data = empty ? '0 : mem[head].data;
    assign wr_pc   = empty ? '0 : mem[head].pc;

    // When push and pop hit the same slot (full), the later set of vld wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            vld  <= '0;
        end else begin
            if (pop) begin
                head      <= head + PTR_W'(1);
                vld[head] <= 1'b0;
            end
            if (push) begin
                tail      <= tail + PTR_W'(1);
                vld[tail] <= 1'b1;
            end
            cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[tail] <= '{addr: in_addr, data: in_data, pc: in_pc};
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign m_addr[g] = mem[g].addr;
        assign m_data[g] = mem[g].data;
    end

    grf_wb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_look1 (
        .valid     (vld),
        .addr      (m_addr),
        .data      (m_data),
        .tail      (tail),
        .look_addr (look1_addr),
        .hit       (look1_hit),
        .look_data (look1_data)
    );

    grf_wb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_look2 (
        .valid     (vld),
        .addr      (m_addr),
        .data      (m_data),
        .tail      (tail),
        .look_addr (look2_addr),
        .hit       (look2_hit),
        .look_data (look2_data)
    );

endmodule

// File: tb/tb_grf_wb_queue.sv
// tb_grf_wb_queue: directed and random checks of grf_wb_queue against a queue/regfile model.
module tb_grf_wb_queue;

    import grf_wb_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          drain_en = 1'b0;
    logic [AW-1:0] in_addr = '0;
    logic [AW-1:0] look1_addr = '0;
    logic [AW-1:0] look2_addr = '0;
    logic [DW-1:0] in_data = '0;
    logic [DW-1:0] in_pc = '0;
    logic          in_ready, wr_en, look1_hit, look2_hit, empty, full;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data, wr_pc, look1_data, look2_data;
    logic [2:0]    count;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            pushes = 0;
    bit            chk_on = 1'b1;
    wb_entry_t     q[$];
    logic [AW-1:0] commit_log[$];
    logic [DW-1:0] model_rf [32];
    logic [DW-1:0] dut_rf [32];

    grf_wb_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .in_pc      (in_pc),
        .drain_en   (drain_en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_pc      (wr_pc),
        .look1_addr (look1_addr),
        .look1_hit  (look1_hit),
        .look1_data (look1_data),
        .look2_addr (look2_addr),
        .look2_hit  (look2_hit),
        .look2_data (look2_data),
        .count      (count),
        .empty      (empty),
        .full       (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void look(input logic [AW-1:0] a, output logic h, output logic [DW-1:0] d);
        h = 1'b0;
        d = '0;
        if (a != '0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].addr == a) begin
                    h = 1'b1;
                    d = q[i].data;
                    break;
                end
            end
        end
    endfunction

    // Model: a plain FIFO of pending writes plus the register file they land in.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
        end else begin
            bit pop_m, rdy_m;
            pop_m = drain_en && q.size() > 0;
            rdy_m = q.size() < DEPTH || pop_m;
            if (pop_m) begin
                model_rf[q[0].addr] = q[0].data;
                void'(q.pop_front());
            end
            if (in_valid && rdy_m && in_addr != '0) begin
                q.push_back('{addr: in_addr, data: in_data, pc: in_pc});
                pushes++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            logic          ew, h1, h2;
            logic [DW-1:0] d1, d2;
            ew = reset_n && drain_en && q.size() > 0;
            chk("wr_en", wr_en, ew);
            if (ew) begin
                chk("wr_addr", wr_addr, q[0].addr);
                chk("wr_data", wr_data, q[0].data);
                chk("wr_pc", wr_pc, q[0].pc);
            end else if (q.size() == 0) begin
                chk("wr_addr_idle", wr_addr, 0);
                chk("wr_data_idle", wr_data, 0);
                chk("wr_pc_idle", wr_pc, 0);
            end
            chk("count", count, q.size());
            chk("empty", empty, q.size() == 0);
            chk("full", full, q.size() == DEPTH);
            chk("in_ready", in_ready, reset_n && (q.size() < DEPTH || ew));
            look(look1_addr, h1, d1);
            look(look2_addr, h2, d2);
            chk("look1_hit", look1_hit, h1);
            chk("look1_data", look1_data, d1);
            chk("look2_hit", look2_hit, h2);
            chk("look2_data", look2_data, d2);
            if (wr_en) begin
                dut_rf[wr_addr] = wr_data;
                commit_log.push_back(wr_addr);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] p);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        in_pc    = p;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        logic rdy_s;
        rdy_s = 1'b0;
        for (int r = 0; r < 32; r++) begin
            model_rf[r] = '0;
            dut_rf[r]   = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_wr_en", wr_en, 0);
        reset_n = 1'b1;

        drain_en = 1'b1;
        push1(5'd8, 32'h1234_5678, 32'h3000);
        chk("t1_wr_en", wr_en, 1);
        chk("t1_wr_addr", wr_addr, 8);
        chk("t1_wr_data", wr_data, 32'h1234_5678);
        chk("t1_wr_pc", wr_pc, 32'h3000);
        chk("t1_count", count, 1);
        step();
        chk("t1_count_after", count, 0);
        chk("t1_wr_en_after", wr_en, 0);

        drain_en = 1'b0;
        for (int i = 1; i <= 4; i++) push1(AW'(i), 32'h100 + DW'(i), 32'h4000 + DW'(4 * i));
        chk("t2_full", full, 1);
        chk("t2_in_ready", in_ready, 0);
        chk("t2_count", count, 4);
        push1(5'd7, 32'hdead, 32'h0);
        chk("t2_ignored_count", count, 4);
        commit_log.delete();
        drain_en = 1'b1;
        push1(5'd5, 32'h105, 32'h4014);
        chk("t2_pushpop_count", count, 4);
        repeat (5) step();
        chk("t2_log_size", commit_log.size(), 5);
        for (int i = 0; i < 5; i++) chk($sformatf("t2_order%0d", i), commit_log[i], i + 1);
        chk("t2_empty", empty, 1);

        in_valid = 1'b1;
        in_addr  = '0;
        in_data  = 32'hFFFF_FFFF;
        in_pc    = '0;
        #3;
        chk("t3_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("t3_count", count, 0);
        commit_log.delete();
        step();
        chk("t3_no_commit", commit_log.size(), 0);

        drain_en = 1'b0;
        push1(5'd9, 32'h11, 32'h5000);
        push1(5'd9, 32'h22, 32'h5004);
        look1_addr = 5'd9;
        look2_addr = 5'd0;
        #1;
        chk("t4_look1_hit", look1_hit, 1);
        chk("t4_look1_data", look1_data, 32'h22);
        chk("t4_look2_hit", look2_hit, 0);
        chk("t4_look2_data", look2_data, 0);
        drain_en = 1'b1;
        step();
        drain_en = 1'b0;
        #1;
        chk("t4_count", count, 1);
        chk("t4_look1_hit_after", look1_hit, 1);
        chk("t4_look1_data_after", look1_data, 32'h22);
        drain_en = 1'b1;
        repeat (2) step();
        look1_addr = '0;

        drain_en = 1'b0;
        push1(5'd10, 32'hA0, 32'h6000);
        push1(5'd11, 32'hB0, 32'h6004);
        push1(5'd12, 32'hC0, 32'h6008);
        drain_en = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_wr_en", wr_en, 0);
        chk("t5_count", count, 0);
        chk("t5_in_ready", in_ready, 0);
        chk("t5_empty", empty, 1);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        commit_log.delete();
        repeat (3) step();
        chk("t5_no_commit", commit_log.size(), 0);
        chk("t5_count_after", count, 0);

        for (int c = 0; c < 600; c++) begin
            if (!(in_valid && !rdy_s)) begin
                in_valid = $urandom_range(0, 3) != 0;
                in_addr  = AW'($urandom_range(0, 31));
                in_data  = $urandom;
                in_pc    = $urandom;
            end
            drain_en   = $urandom_range(0, 2) != 0;
            look1_addr = AW'($urandom_range(0, 31));
            look2_addr = AW'($urandom_range(0, 31));
            #3;
            rdy_s = in_ready;
            step();
        end
        in_valid = 1'b0;
        drain_en = 1'b1;
        repeat (DEPTH + 2) step();
        chk("t6_empty", empty, 1);
        for (int r = 1; r < 32; r++) chk($sformatf("rf%0d", r), dut_rf[r], model_rf[r]);

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
